// File: rtl/dac_spi_multi_if.sv
// Host-side bundle of the multi-channel DAC SPI writer: request, status and DAC pins.
interface dac_spi_multi_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4
);
    logic                     enable;
    logic                     start;
    logic [NUM_CH-1:0]        ch_mask;
    logic [NUM_CH*DATA_W-1:0] data_in;
    logic                     busy;
    logic                     done;
    logic [2:0]               ch_idx;
    logic                     cs;
    logic                     sck;
    logic                     sdi;
    logic                     ldac;

    modport master (
        output enable, start, ch_mask, data_in,
        input  busy, done, ch_idx, cs, sck, sdi, ldac
    );

    modport slave (
        input  enable, start, ch_mask, data_in,
        output busy, done, ch_idx, cs, sck, sdi, ldac
    );
endinterface

// File: rtl/dac_spi_multi.sv
// Serialises the masked channel words to a DAC over SPI (mode 0, MSB first),
// with a cs-high gap after each frame and an ldac load strobe either after
// every frame or only after the last one. All outputs are registered.
module dac_spi_multi #(
    parameter int DATA_W    = 16,
    parameter int NUM_CH    = 4,
    parameter int SCK_DIV   = 2,
    parameter int T_LS      = 3,
    parameter int T_LD      = 6,
    parameter int LDAC_MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    dac_spi_multi_if.slave  bus
);
    localparam int TMR_M1  = (SCK_DIV > T_LS) ? SCK_DIV : T_LS;
    localparam int TMR_MAX = (TMR_M1 > T_LD) ? TMR_M1 : T_LD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W);

    localparam logic [TMR_W-1:0] SCK_LAST = TMR_W'(SCK_DIV - 1);
    localparam logic [TMR_W-1:0] LS_LAST  = TMR_W'(T_LS - 1);
    // One cycle shorter variants: the final gap cycle is spent in NEXT.
    localparam logic [TMR_W-1:0] LS_PRE   = TMR_W'(T_LS - 2);
    localparam logic [TMR_W-1:0] LD_LAST  = TMR_W'(T_LD - 1);
    localparam logic [TMR_W-1:0] LD_PRE   = TMR_W'(T_LD - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, CS_GAP, LDAC_LO, NEXT} state_t;

    state_t                   state_q, state_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [NUM_CH-1:0]        mask_q, mask_d;
    logic [NUM_CH*DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0]        shreg_q, shreg_d;
    logic [2:0]               ch_idx_q, ch_idx_d;
    logic                     cs_q, cs_d, sck_q, sck_d, sdi_q, sdi_d;
    logic                     ldac_q, ldac_d, busy_q, busy_d, done_q, done_d;

    logic                     load, more;
    logic [NUM_CH-1:0]        src_mask;
    logic [NUM_CH*DATA_W-1:0] src_data;
    logic [2:0]               nxt_ch;
    logic [DATA_W-1:0]        nxt_word;

    function automatic logic [2:0] first_set(input logic [NUM_CH-1:0] m);
        first_set = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i]) first_set = 3'(i);
    endfunction

    function automatic logic [NUM_CH-1:0] clr_bit(input logic [NUM_CH-1:0] m, input logic [2:0] idx);
        clr_bit = m;
        for (int i = 0; i < NUM_CH; i++)
            if (idx == 3'(i)) clr_bit[i] = 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] word_of(input logic [NUM_CH*DATA_W-1:0] d, input logic [2:0] idx);
        word_of = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (idx == 3'(i)) word_of = d[i*DATA_W +: DATA_W];
    endfunction

    // Next-state and next-output logic; mask_q holds the channels still to send.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        bit_d    = bit_q;
        mask_d   = mask_q;
        data_d   = data_q;
        shreg_d  = shreg_q;
        ch_idx_d = ch_idx_q;
        cs_d     = cs_q;
        sck_d    = sck_q;
        sdi_d    = sdi_q;
        ldac_d   = ldac_q;
        done_d   = 1'b0;
        load     = 1'b0;
        src_mask = mask_q;
        src_data = data_q;
        more     = |mask_q;
        nxt_ch   = 3'd0;
        nxt_word = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mask_d = bus.ch_mask;
                    data_d = bus.data_in;
                    if (|bus.ch_mask) begin
                        load     = 1'b1;
                        src_mask = bus.ch_mask;
                        src_data = bus.data_in;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (tmr_q == SCK_LAST) begin
                    tmr_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            cs_d  = 1'b1;
                            sdi_d = 1'b0;
                            bit_d = '0;
                            if (LDAC_MODE == 1 && more && T_LS == 1) state_d = NEXT;
                            else                                     state_d = CS_GAP;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                            sdi_d   = shreg_q[DATA_W-2];
                        end
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            CS_GAP: begin
                if (LDAC_MODE == 1 && more) begin
                    if (tmr_q == LS_PRE) begin
                        tmr_d   = '0;
                        state_d = NEXT;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end else if (tmr_q == LS_LAST) begin
                    tmr_d   = '0;
                    ldac_d  = 1'b0;
                    state_d = (more && T_LD == 1) ? NEXT : LDAC_LO;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            LDAC_LO: begin
                if (more) begin
                    // ldac stays low through NEXT, so cs falls as ldac rises.
                    if (tmr_q == LD_PRE) begin
                        tmr_d   = '0;
                        state_d = NEXT;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end else if (tmr_q == LD_LAST) begin
                    tmr_d   = '0;
                    ldac_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            NEXT: begin
                load = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            nxt_ch   = first_set(src_mask);
            nxt_word = word_of(src_data, nxt_ch);
            ch_idx_d = nxt_ch;
            mask_d   = clr_bit(src_mask, nxt_ch);
            shreg_d  = nxt_word;
            sdi_d    = nxt_word[DATA_W-1];
            cs_d     = 1'b0;
            sck_d    = 1'b0;
            ldac_d   = 1'b1;
            tmr_d    = '0;
            bit_d    = '0;
            state_d  = SHIFT;
        end

        // enable low wins over everything, including a start seen in IDLE.
        if (!bus.enable) begin
            state_d  = IDLE;
            tmr_d    = '0;
            bit_d    = '0;
            mask_d   = '0;
            data_d   = data_q;
            shreg_d  = shreg_q;
            ch_idx_d = ch_idx_q;
            cs_d     = 1'b1;
            sck_d    = 1'b0;
            sdi_d    = 1'b0;
            ldac_d   = 1'b1;
            done_d   = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State, counters, latched request and registered DAC pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            bit_q    <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            shreg_q  <= '0;
            ch_idx_q <= 3'd0;
            cs_q     <= 1'b1;
            sck_q    <= 1'b0;
            sdi_q    <= 1'b0;
            ldac_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bit_q    <= bit_d;
            mask_q   <= mask_d;
            data_q   <= data_d;
            shreg_q  <= shreg_d;
            ch_idx_q <= ch_idx_d;
            cs_q     <= cs_d;
            sck_q    <= sck_d;
            sdi_q    <= sdi_d;
            ldac_q   <= ldac_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.ch_idx = ch_idx_q;
    assign bus.cs     = cs_q;
    assign bus.sck    = sck_q;
    assign bus.sdi    = sdi_q;
    assign bus.ldac   = ldac_q;
endmodule

// File: tb/tb_dac_spi_multi.sv
// Bench for dac_spi_multi: one DUT per ldac policy, an expected-waveform model
// built per transaction from the timing rules, and directed literal checks.
module tb_dac_spi_multi;
    localparam int DW  = 16;
    localparam int NC  = 4;
    localparam int SD  = 2;
    localparam int TLS = 3;
    localparam int TLD = 6;

    typedef struct packed {
        logic       cs, sck, sdi, ldac, busy, done, chk;
        logic [2:0] ch;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dac_spi_multi_if #(.DATA_W(DW), .NUM_CH(NC)) if0 ();
    dac_spi_multi_if #(.DATA_W(DW), .NUM_CH(NC)) if1 ();

    dac_spi_multi #(.DATA_W(DW), .NUM_CH(NC), .SCK_DIV(SD), .T_LS(TLS), .T_LD(TLD), .LDAC_MODE(0))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    dac_spi_multi #(.DATA_W(DW), .NUM_CH(NC), .SCK_DIV(SD), .T_LS(TLS), .T_LD(TLD), .LDAC_MODE(1))
        u1 (.clk(clk), .rst(rst), .bus(if1));

    exp_t q0[$];
    exp_t q1[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   t0 = 0;
    bit   chk_on = 1'b0;

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.cs = 1'b1;
        e.ldac = 1'b1;
        return e;
    endfunction

    task automatic push(input int id, input exp_t e);
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Expected outputs for cycles T+1 onward, derived from the frame/gap/strobe rules.
    task automatic build(input int id, input logic [NC-1:0] m, input logic [NC*DW-1:0] d);
        exp_t e;
        logic [DW-1:0] w;
        int last;
        last = -1;
        for (int i = 0; i < NC; i++) if (m[i]) last = i;
        if (m == '0) begin
            e = idle_e(); e.done = 1'b1; push(id, e);
            return;
        end
        for (int i = 0; i < NC; i++) begin
            if (m[i]) begin
                w = d[i*DW +: DW];
                for (int b = 0; b < DW; b++)
                    for (int c = 0; c < 2*SD; c++) begin
                        e = '0;
                        e.sck = (c >= SD);
                        e.sdi = w[DW-1-b];
                        e.ldac = 1'b1; e.busy = 1'b1; e.chk = 1'b1; e.ch = 3'(i);
                        push(id, e);
                    end
                for (int t = 0; t < TLS; t++) begin
                    e = idle_e(); e.busy = 1'b1; push(id, e);
                end
                if (id == 0 || i == last)
                    for (int t = 0; t < TLD; t++) begin
                        e = idle_e(); e.busy = 1'b1; e.ldac = 1'b0; push(id, e);
                    end
            end
        end
        e = idle_e(); e.done = 1'b1; push(id, e);
    endtask

    task automatic cmp(input int id, input exp_t e, input logic [5:0] a, input logic [2:0] ch);
        logic [5:0] w;
        w = {e.cs, e.sck, e.sdi, e.ldac, e.busy, e.done};
        vectors++;
        if (a !== w || (e.chk && ch !== e.ch)) begin
            miscompares++;
            $display("FAIL model dut%0d cyc %0d: got cs,sck,sdi,ldac,busy,done=%b ch=%0d, want %b ch=%0d",
                     id, cyc, a, ch, w, e.ch);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cyc %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Single compare process: every cycle, both DUTs against their expected queues.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (chk_on) begin
            if (q0.size() > 0) e = q0.pop_front(); else e = idle_e();
            cmp(0, e, {if0.cs, if0.sck, if0.sdi, if0.ldac, if0.busy, if0.done}, if0.ch_idx);
            if (q1.size() > 0) e = q1.pop_front(); else e = idle_e();
            cmp(1, e, {if1.cs, if1.sck, if1.sdi, if1.ldac, if1.busy, if1.done}, if1.ch_idx);
        end
    end

    // Called just after a negedge (cycle T); returns just after the negedge of T+1.
    task automatic go(input int id, input logic [NC-1:0] m, input logic [NC*DW-1:0] d);
        if (id == 0) begin if0.start = 1'b1; if0.ch_mask = m; if0.data_in = d; end
        else         begin if1.start = 1'b1; if1.ch_mask = m; if1.data_in = d; end
        t0 = cyc;
        build(id, m, d);
        @(negedge clk); #1;
        if (id == 0) begin if0.start = 1'b0; if0.ch_mask = ~m; if0.data_in = ~d; end
        else         begin if1.start = 1'b0; if1.ch_mask = ~m; if1.data_in = ~d; end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_idle(input int id);
        int b;
        b = 0;
        while (((id == 0) ? q0.size() : q1.size()) > 0 && b < 2000) begin
            @(negedge clk); #1; b++;
        end
        vectors++;
        if (b >= 2000) begin
            miscompares++;
            $display("FAIL timeout dut%0d: got no completion within 2000 cycles, want done", id);
        end
    endtask

    initial begin
        logic [15:0] cap;
        int ld_cnt;
        if0.enable = 1'b1; if0.start = 1'b0; if0.ch_mask = '0; if0.data_in = '0;
        if1.enable = 1'b1; if1.start = 1'b0; if1.ch_mask = '0; if1.data_in = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cs", 32'(if0.cs), 32'd1);
        chk("rst_sck", 32'(if0.sck), 32'd0);
        chk("rst_sdi", 32'(if0.sdi), 32'd0);
        chk("rst_ldac", 32'(if0.ldac), 32'd1);
        chk("rst_busy", 32'(if0.busy), 32'd0);
        chk("rst_done", 32'(if0.done), 32'd0);
        chk("rst_chidx", 32'(if0.ch_idx), 32'd0);
        rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk); #1;

        // Single channel 0xA5C3
        go(0, 4'b0001, 64'h0000_0000_0000_A5C3);
        cap = '0;
        while (cyc < t0 + 74) begin
            int n;
            @(negedge clk); #1;
            n = cyc - t0;
            if (n >= 1 && n <= 64 && ((n - 1) % 4) == 2) cap = {cap[14:0], if0.sdi};
            if (n == 64) chk("a_cs_low_end", 32'(if0.cs), 32'd0);
            if (n == 65) chk("a_cs_rise", 32'(if0.cs), 32'd1);
            if (n == 67) chk("a_ldac_pre", 32'(if0.ldac), 32'd1);
            if (n == 68) chk("a_ldac_fall", 32'(if0.ldac), 32'd0);
            if (n == 73) chk("a_ldac_last", 32'(if0.ldac), 32'd0);
            if (n == 74) begin
                chk("a_done", 32'(if0.done), 32'd1);
                chk("a_busy", 32'(if0.busy), 32'd0);
            end
        end
        chk("a_sdi_word", 32'(cap), 32'h0000_A5C3);

        // Two channels, back-to-back from the done cycle, with an ignored start mid-frame
        go(0, 4'b0101, 64'h0000_FFFF_0000_1234);
        while (cyc < t0 + 147) begin
            int n;
            @(negedge clk); #1;
            n = cyc - t0;
            if (n == 40) begin if0.start = 1'b1; if0.ch_mask = 4'b1111; end
            if (n == 41) if0.start = 1'b0;
            if (n == 73) chk("b_ldac1_low", 32'(if0.ldac), 32'd0);
            if (n == 74) begin
                chk("b_cs2_fall", 32'(if0.cs), 32'd0);
                chk("b_ldac1_rise", 32'(if0.ldac), 32'd1);
            end
            if (n == 84) chk("b_chidx2", 32'(if0.ch_idx), 32'd2);
            if (n == 147) chk("b_done", 32'(if0.done), 32'd1);
        end

        // Four channels, ldac only after the last frame
        go(1, 4'b1111, 64'h8001_0F0F_3C3C_5555);
        ld_cnt = 0;
        while (cyc < t0 + 275) begin
            int n;
            @(negedge clk); #1;
            n = cyc - t0;
            if (!if1.ldac) ld_cnt++;
            if (n == 65) chk("c_gap_1", 32'(if1.cs), 32'd1);
            if (n == 67) chk("c_gap_3", 32'(if1.cs), 32'd1);
            if (n == 68) chk("c_cs2_fall", 32'(if1.cs), 32'd0);
            if (n == 268) chk("c_ldac_pre", 32'(if1.ldac), 32'd1);
            if (n == 269) chk("c_ldac_fall", 32'(if1.ldac), 32'd0);
            if (n == 275) chk("c_done", 32'(if1.done), 32'd1);
        end
        chk("c_ldac_width", 32'(ld_cnt), 32'd6);

        // Empty mask
        go(0, 4'b0000, 64'h1111_2222_3333_4444);
        chk("d_done", 32'(if0.done), 32'd1);
        chk("d_busy", 32'(if0.busy), 32'd0);
        wait_to(t0 + 3);

        // enable dropped at T+20
        go(0, 4'b0011, 64'h0000_0000_BEEF_CAFE);
        wait_to(t0 + 20);
        if0.enable = 1'b0;
        q0.delete();
        wait_to(t0 + 21);
        chk("e_cs", 32'(if0.cs), 32'd1);
        chk("e_sck", 32'(if0.sck), 32'd0);
        chk("e_sdi", 32'(if0.sdi), 32'd0);
        chk("e_ldac", 32'(if0.ldac), 32'd1);
        chk("e_busy", 32'(if0.busy), 32'd0);
        wait_to(t0 + 26);
        if0.enable = 1'b1;
        wait_to(t0 + 28);

        // rst pulsed mid-LDAC_LO, then a normal restart
        go(0, 4'b0001, 64'h0000_0000_0000_00FF);
        wait_to(t0 + 70);
        chk("f_ldac_low", 32'(if0.ldac), 32'd0);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        chk("f_ldac_async", 32'(if0.ldac), 32'd1);
        chk("f_busy_async", 32'(if0.busy), 32'd0);
        wait_to(t0 + 73);
        rst = 1'b0;
        wait_to(t0 + 80);
        go(0, 4'b1000, 64'h0F0F_0000_0000_0000);
        wait_idle(0);
        chk("f_restart_done", 32'(if0.done), 32'd1);

        // Sparse mask on the single-strobe DUT
        go(1, 4'b1010, 64'h9876_0000_4321_0000);
        wait_idle(1);
        chk("g_done", 32'(if1.done), 32'd1);
        repeat (4) @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
